// File: rtl/sm3_pad_arb_pkg.sv
// Purpose: shared types and the round-robin selection helper for the SM3 pad arbiter.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package sm3_pad_arb_pkg;

    // Upper bound on requesters; the helper works on vectors padded to this width.
    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // First set bit of req scanning ptr, ptr+1, ... (mod n). Only the low n bits
    // of req are considered; ptr must be below n. Returns ptr when nothing is set.
    function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req,
                                           input logic [2:0]        ptr,
                                           input int                n);
        logic [2:0] sel;
        int         idx;
        sel = ptr;
        // Walk from the farthest candidate back to ptr so the nearest hit is written last.
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = int'(ptr) + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[2:0]]) begin
                    sel = idx[2:0];
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sm3_rr_picker.sv
// Purpose: combinational round-robin picker, first requester at or after ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req (request vector), ptr (scan start), pick (chosen index), any (some request set).
module sm3_rr_picker
    import sm3_pad_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int IDW  = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  pick,
    output logic            any
);

    assign pick = IDW'(rr_pick(MAX_CH'(req), 3'(ptr), N_CH));
    assign any  = |req;

endmodule

// File: rtl/sm3_pad_arbiter.sv
// Purpose: shares one SM3 pad core among N_CH requesters, one whole message per grant, output tagged with owner id.
// Latency: 1 cycle grant in IDLE, then beats pass combinationally from owner to core until the core's last pad block.
// Backpressure: owner's ready mirrors core ready; all other requesters see ready low.
// Ports: clk, rst_n (async, active low); req_* per-channel message streams (ch k at slice k);
//   core_msg_* muxed stream to the pad core; core_pad_vld_i/core_pad_lst_i/pad_otpt_ena_i end the drain;
//   own_id_o current owner; busy_o high while a message is in flight or draining.
// Build option: define SM3_ARB_PRIO0_EN to give channel 0 absolute priority at grant time.
module sm3_pad_arbiter
    import sm3_pad_arb_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int INPT_DW = 32,
    localparam int BW      = INPT_DW / 8,
    localparam int IDW     = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*INPT_DW-1:0] req_d_i,
    input  logic [N_CH*BW-1:0]    req_vld_byte_i,
    input  logic [N_CH-1:0]       req_vld_i,
    input  logic [N_CH-1:0]       req_lst_i,
    output logic [N_CH-1:0]       req_rdy_o,
    output logic [INPT_DW-1:0]    core_msg_d_o,
    output logic [BW-1:0]         core_msg_vld_byte_o,
    output logic                  core_msg_vld_o,
    output logic                  core_msg_lst_o,
    input  logic                  core_msg_rdy_i,
    input  logic                  core_pad_vld_i,
    input  logic                  core_pad_lst_i,
    input  logic                  pad_otpt_ena_i,
    output logic [IDW-1:0]        own_id_o,
    output logic                  busy_o
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] own_q, own_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] rr_id;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] own_inc;
    logic           any_req;
    logic           own_vld;

    sm3_rr_picker #(
        .N_CH (N_CH),
        .IDW  (IDW)
    ) u_picker (
        .req  (req_vld_i),
        .ptr  (rr_ptr_q),
        .pick (rr_id),
        .any  (any_req)
    );

`ifdef SM3_ARB_PRIO0_EN
    assign grant_id = req_vld_i[0] ? '0 : rr_id;
`else
    assign grant_id = rr_id;
`endif

    // Pointer moves just past the finished owner; explicit wrap keeps non-power-of-2 N_CH correct.
    assign own_inc = (own_q == IDW'(N_CH - 1)) ? '0 : own_q + IDW'(1);
    assign own_vld = req_vld_i[own_q];

    always_comb begin
        state_d             = state_q;
        own_d               = own_q;
        rr_ptr_d            = rr_ptr_q;
        req_rdy_o           = '0;
        core_msg_d_o        = '0;
        core_msg_vld_byte_o = '0;
        core_msg_vld_o      = 1'b0;
        core_msg_lst_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    own_d   = grant_id;
                    state_d = XFER;
                end
            end
            XFER: begin
                core_msg_vld_o   = own_vld;
                req_rdy_o[own_q] = core_msg_rdy_i;
                // Data and byte valids are forced to zero whenever no beat is offered.
                if (own_vld) begin
                    core_msg_d_o        = req_d_i[own_q*INPT_DW +: INPT_DW];
                    core_msg_vld_byte_o = req_vld_byte_i[own_q*BW +: BW];
                    core_msg_lst_o      = req_lst_i[own_q];
                end
                if (own_vld && core_msg_rdy_i && req_lst_i[own_q]) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (core_pad_vld_i && core_pad_lst_i && pad_otpt_ena_i) begin
                    state_d = IDLE;
`ifdef SM3_ARB_PRIO0_EN
                    // A channel-0 grant must not disturb the rotation among the others.
                    if (own_q != '0) begin
                        rr_ptr_d = own_inc;
                    end
`else
                    rr_ptr_d = own_inc;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            own_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign own_id_o = own_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_sm3_pad_arbiter.sv
// Purpose: self-checking bench for sm3_pad_arbiter against a transaction-level model of the arbitration rules.
// Latency: n/a.
// Backpressure: randomised core ready, requester valid and downstream enable.
module tb_sm3_pad_arbiter;

    localparam int N_CH    = 4;
    localparam int INPT_DW = 32;
    localparam int BW      = INPT_DW / 8;
    localparam int IDW     = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N_CH*INPT_DW-1:0] req_d;
    logic [N_CH*BW-1:0]      req_vld_byte;
    logic [N_CH-1:0]         req_vld;
    logic [N_CH-1:0]         req_lst;
    logic [N_CH-1:0]         req_rdy;
    logic [INPT_DW-1:0]      core_msg_d;
    logic [BW-1:0]           core_msg_vld_byte;
    logic                    core_msg_vld;
    logic                    core_msg_lst;
    logic                    core_msg_rdy;
    logic                    core_pad_vld;
    logic                    core_pad_lst;
    logic                    pad_otpt_ena;
    logic [IDW-1:0]          own_id;
    logic                    busy;

    always #5 clk = ~clk;

    sm3_pad_arbiter #(.N_CH(N_CH), .INPT_DW(INPT_DW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_d_i             (req_d),
        .req_vld_byte_i      (req_vld_byte),
        .req_vld_i           (req_vld),
        .req_lst_i           (req_lst),
        .req_rdy_o           (req_rdy),
        .core_msg_d_o        (core_msg_d),
        .core_msg_vld_byte_o (core_msg_vld_byte),
        .core_msg_vld_o      (core_msg_vld),
        .core_msg_lst_o      (core_msg_lst),
        .core_msg_rdy_i      (core_msg_rdy),
        .core_pad_vld_i      (core_pad_vld),
        .core_pad_lst_i      (core_pad_lst),
        .pad_otpt_ena_i      (pad_otpt_ena),
        .own_id_o            (own_id),
        .busy_o              (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Per-channel message under test: words, byte valids, position, messages still to send.
    logic [INPT_DW-1:0] m_words [N_CH][$];
    logic [BW-1:0]      m_bytes [N_CH][$];
    int                 m_idx   [N_CH];
    int                 m_left  [N_CH];

    // Transaction-level view of the arbiter and the pad core.
    bit  m_busy, m_xfer;
    int  m_own, m_ptr;
    int  pad_wait, ena_hold, drain_len;
    int  cyc;
    int  grants[$];
    int  grant_cyc[$];
    int  acc_cyc[$];
    logic [BW-1:0] last_byte;

    // Stimulus knobs.
    int  k_lenmin, k_lenmax, k_vld_pct, k_rdy_mode, k_ena_mode, k_padwait_max;
    bit  k_byte_force;

    function automatic bit has_msg(input int ch);
        return m_idx[ch] < m_words[ch].size();
    endfunction

    function automatic bit phase_done();
        for (int ch = 0; ch < N_CH; ch++) if (m_left[ch] != 0) return 1'b0;
        return !m_busy;
    endfunction

    function automatic int model_pick(input logic [N_CH-1:0] v);
`ifdef SM3_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N_CH; k++) if (v[(m_ptr + k) % N_CH]) return (m_ptr + k) % N_CH;
        return -1;
    endfunction

    task automatic new_msg(input int ch);
        int len;
        len = $urandom_range(k_lenmin, k_lenmax);
        m_words[ch].delete();
        m_bytes[ch].delete();
        m_idx[ch] = 0;
        for (int i = 0; i < len; i++) begin
            m_words[ch].push_back($urandom);
            if (k_byte_force)      m_bytes[ch].push_back(4'b0011);
            else if (i == len - 1) m_bytes[ch].push_back(BW'($urandom_range(1, 15)));
            else                   m_bytes[ch].push_back('1);
        end
    endtask

    task automatic setup(input logic [N_CH-1:0] mask, input int nmsg);
        grants.delete();
        grant_cyc.delete();
        acc_cyc.delete();
        for (int ch = 0; ch < N_CH; ch++) begin
            m_words[ch].delete();
            m_bytes[ch].delete();
            m_idx[ch]  = 0;
            m_left[ch] = 0;
            if (mask[ch]) begin
                m_left[ch] = nmsg;
                new_msg(ch);
            end
        end
    endtask

    task automatic zero_inputs();
        req_d        = '0;
        req_vld_byte = '0;
        req_vld      = '0;
        req_lst      = '0;
        core_msg_rdy = 1'b0;
        core_pad_vld = 1'b0;
        core_pad_lst = 1'b0;
        pad_otpt_ena = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        zero_inputs();
        m_busy = 0; m_xfer = 0; m_ptr = 0; m_own = 0; pad_wait = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at the falling edge, check the combinational response, then advance the model.
    task automatic step();
        logic [N_CH-1:0] exp_rdy;
        logic            exp_vld;
        int              p;
        @(negedge clk);
        cyc++;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (has_msg(ch)) begin
                req_vld[ch]                   = ($urandom_range(0, 99) < k_vld_pct);
                req_d[ch*INPT_DW +: INPT_DW]  = m_words[ch][m_idx[ch]];
                req_vld_byte[ch*BW +: BW]     = m_bytes[ch][m_idx[ch]];
                req_lst[ch]                   = (m_idx[ch] == m_words[ch].size() - 1);
            end else begin
                req_vld[ch]                   = 1'b0;
                req_d[ch*INPT_DW +: INPT_DW]  = '0;
                req_vld_byte[ch*BW +: BW]     = '0;
                req_lst[ch]                   = 1'b0;
            end
        end
        case (k_rdy_mode)
            0:       core_msg_rdy = 1'b1;
            1:       core_msg_rdy = (cyc % 2 == 0);
            default: core_msg_rdy = 1'($urandom_range(0, 1));
        endcase
        if (m_busy && !m_xfer && pad_wait == 0) begin
            core_pad_vld = 1'b1;
            core_pad_lst = 1'b1;
            case (k_ena_mode)
                0:       pad_otpt_ena = 1'b1;
                1:       pad_otpt_ena = 1'($urandom_range(0, 1));
                default: pad_otpt_ena = (ena_hold == 0);
            endcase
        end else begin
            core_pad_vld = 1'($urandom_range(0, 1));
            core_pad_lst = 1'b0;
            pad_otpt_ena = 1'($urandom_range(0, 1));
        end
        #1;
        exp_vld = m_xfer && req_vld[m_own];
        exp_rdy = m_xfer ? (N_CH'(core_msg_rdy) << m_own) : '0;
        check("busy", busy, m_busy);
        if (m_busy) check("own_id", own_id, m_own);
        check("core_vld", core_msg_vld, exp_vld);
        check("req_rdy", req_rdy, exp_rdy);
        if (exp_vld) begin
            check("core_d", core_msg_d, m_words[m_own][m_idx[m_own]]);
            check("core_byte", core_msg_vld_byte, m_bytes[m_own][m_idx[m_own]]);
            check("core_lst", core_msg_lst, m_idx[m_own] == m_words[m_own].size() - 1);
        end else begin
            check("core_d_idle", core_msg_d, 0);
            check("core_byte_idle", core_msg_vld_byte, 0);
        end
        if (!m_busy) begin
            p = model_pick(req_vld);
            if (p >= 0) begin
                m_busy = 1; m_xfer = 1; m_own = p;
                grants.push_back(p);
                grant_cyc.push_back(cyc);
            end
        end else if (m_xfer) begin
            if (req_vld[m_own] && core_msg_rdy) begin
                acc_cyc.push_back(cyc);
                last_byte = m_bytes[m_own][m_idx[m_own]];
                m_idx[m_own]++;
                if (!has_msg(m_own)) begin
                    m_xfer    = 0;
                    pad_wait  = $urandom_range(0, k_padwait_max);
                    ena_hold  = 3;
                    drain_len = 0;
                    m_left[m_own]--;
                    if (m_left[m_own] > 0) new_msg(m_own);
                end
            end
        end else begin
            drain_len++;
            if (core_pad_vld && core_pad_lst && pad_otpt_ena) begin
                m_busy = 0;
`ifdef SM3_ARB_PRIO0_EN
                if (m_own != 0) m_ptr = (m_own + 1) % N_CH;
`else
                m_ptr = (m_own + 1) % N_CH;
`endif
            end else if (pad_wait > 0) begin
                pad_wait--;
            end else if (ena_hold > 0) begin
                ena_hold--;
            end
        end
    endtask

    task automatic run_phase(input string tag, input int budget);
        int n;
        n = 0;
        while (!phase_done() && n < budget) begin
            step();
            n++;
        end
        check(tag, phase_done(), 1);
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        int c0;
        int exp_order[5];
        zero_inputs();
        cyc = 0; m_busy = 0; m_xfer = 0; m_ptr = 0; m_own = 0;
        pad_wait = 0; ena_hold = 0; drain_len = 0; last_byte = '0;
        for (int ch = 0; ch < N_CH; ch++) begin m_idx[ch] = 0; m_left[ch] = 0; end
        k_lenmin = 1; k_lenmax = 3; k_vld_pct = 100; k_rdy_mode = 0;
        k_ena_mode = 0; k_padwait_max = 3; k_byte_force = 0;

        // Reset values while rst_n is held low with a request pending.
        req_vld = '1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_own", own_id, 0);
        check("rst_rdy", req_rdy, 0);
        check("rst_core_vld", core_msg_vld, 0);
        zero_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Channel 2 alone, 3 beats, core always ready.
        k_lenmin = 3; k_lenmax = 3;
        setup(4'b0100, 1);
        c0 = cyc;
        run_phase("t1_done", 200);
        check("t1_grant_id", q_at(grants, 0), 2);
        check("t1_grant_cyc", q_at(grant_cyc, 0) - c0, 1);
        check("t1_nbeats", acc_cyc.size(), 3);
        for (int i = 0; i < 3; i++) check("t1_beat_cyc", q_at(acc_cyc, i) - c0, 2 + i);

        // All channels from reset: 0,1,2,3 then 0 again.
        do_reset();
        k_lenmin = 1; k_lenmax = 3;
        setup(4'b1111, 1);
        m_left[0] = 2;
        run_phase("t2_done", 400);
`ifdef SM3_ARB_PRIO0_EN
        exp_order = '{0, 0, 1, 2, 3};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        check("t2_ngrants", grants.size(), 5);
        for (int i = 0; i < 5; i++) check("t2_order", q_at(grants, i), exp_order[i]);

        // Alternating core ready: every beat exactly once.
        k_lenmin = 6; k_lenmax = 6; k_rdy_mode = 1;
        setup(4'b0010, 1);
        run_phase("t3_done", 200);
        check("t3_nbeats", acc_cyc.size(), 6);

        // Single-beat message with partial byte valids.
        k_lenmin = 1; k_lenmax = 1; k_rdy_mode = 0; k_byte_force = 1;
        setup(4'b1000, 1);
        run_phase("t4_done", 100);
        check("t4_byte", last_byte, 4'b0011);
        check("t4_xfer_len", q_at(acc_cyc, 0) - q_at(grant_cyc, 0), 1);
        k_byte_force = 0;

        // Pad last held with enable low for three cycles.
        k_padwait_max = 0; k_ena_mode = 2;
        setup(4'b0001, 1);
        run_phase("t5_done", 100);
        check("t5_drain_len", drain_len, 4);

`ifdef SM3_ARB_PRIO0_EN
        // Channel 0 wins every grant while it keeps requesting.
        k_ena_mode = 0; k_lenmin = 1; k_lenmax = 2;
        setup(4'b1001, 3);
        m_left[3] = 1;
        run_phase("prio_done", 300);
        exp_order = '{0, 0, 0, 3, 3};
        for (int i = 0; i < 4; i++) check("prio_order", q_at(grants, i), exp_order[i]);
`endif

        // Randomised traffic on all channels.
        k_lenmin = 1; k_lenmax = 5; k_vld_pct = 70; k_rdy_mode = 2;
        k_ena_mode = 1; k_padwait_max = 3;
        setup(4'b1111, 4);
        run_phase("rand_done", 4000);

        // Asynchronous reset in the middle of a transfer.
        k_lenmin = 8; k_lenmax = 8; k_vld_pct = 100; k_rdy_mode = 0; k_ena_mode = 0;
        setup(4'b0100, 1);
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        check("t6_pre_busy", busy, 1);
        req_vld[2]   = 1'b1;
        core_msg_rdy = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rdy", req_rdy, 0);
        check("t6_busy", busy, 0);
        check("t6_core_vld", core_msg_vld, 0);
        check("t6_own", own_id, 0);
        zero_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
